// File: rtl/bin_energy_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bin_energy_pkg
// Description : Shared widths, sample type and averaging-exponent cap for
//               the per-bin energy accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_energy_pkg;

  localparam int PWR_W  = 32;
  localparam int ACC_W  = 48;
  localparam int CPLX_W = 16;

  // 2^15 vectors of 2^31 peak power still fit in the 48-bit accumulator
  localparam int unsigned AVG_LOG2_CAP = 15;

  typedef struct packed {
    logic signed [CPLX_W-1:0] i;
    logic signed [CPLX_W-1:0] q;
  } cplx_t;

endpackage
`default_nettype wire

// File: rtl/bin_power_sq.sv
`default_nettype none
// ============================================================================
// Module      : bin_power_sq
// Description : Signed 16x16 squarer-adder, I*I + Q*Q, one enable-gated stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_power_sq
  import bin_energy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  cplx_t            i_smp,
  output logic [PWR_W-1:0] o_pwr
);

  logic signed [PWR_W-1:0] w_ii;
  logic signed [PWR_W-1:0] w_qq;

  // Each square is at most 2^30, so the unsigned sum fits in 32 bits
  assign w_ii = PWR_W'($signed(i_smp.i)) * PWR_W'($signed(i_smp.i));
  assign w_qq = PWR_W'($signed(i_smp.q)) * PWR_W'($signed(i_smp.q));

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pwr <= '0;
    end else if (i_en) begin
      o_pwr <= w_ii + w_qq;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin_energy_accum.sv
`default_nettype none
// ============================================================================
// Module      : bin_energy_accum
// Description : Per-bin I^2+Q^2 estimator averaging 2^k FFT vectors in a RAM.
//               Optional BIN_ENERGY_ACCUM_MAXHOLD_EN adds max-hold mode.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_energy_accum
  import bin_energy_pkg::*;
#(
  parameter int VLEN         = 1024,
  parameter int MAX_AVG_LOG2 = 15
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic [3:0]  cfg_avg_log2,
`ifdef BIN_ENERGY_ACCUM_MAXHOLD_EN
  input  logic        cfg_max_hold,
`endif
  input  logic        clear,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        err_len,
  output logic [15:0] vec_cnt
);

  localparam int BIN_W = $clog2(VLEN);
  localparam logic [BIN_W-1:0] c_LAST_BIN = BIN_W'(VLEN - 1);
  localparam int unsigned c_K_MAX_I =
    (MAX_AVG_LOG2 > int'(AVG_LOG2_CAP)) ? AVG_LOG2_CAP : MAX_AVG_LOG2;
  localparam logic [3:0] c_K_MAX = 4'(c_K_MAX_I);

  logic w_en, w_cfg_max, w_grp_start, w_first, w_last_vec;
  logic w_take, w_len_err, w_kill, w_mx, w_s3_load, w_we;
  logic [3:0]  w_cfg_k, w_k;
  logic [15:0] w_vec_max;

  logic [BIN_W-1:0] r_bin;
  logic [15:0]      r_vec;
  logic [3:0]       r_k;
  logic             r_max, r_grp;

  assign w_en     = !o_tvalid || o_tready;
  assign i_tready = w_en;

`ifdef BIN_ENERGY_ACCUM_MAXHOLD_EN
  assign w_cfg_max = cfg_max_hold;
`else
  assign w_cfg_max = 1'b0;
`endif

  // Group configuration is only taken on the first beat of a group
  assign w_grp_start = (r_vec == '0) && (r_bin == '0);
  assign w_cfg_k     = (cfg_avg_log2 > c_K_MAX) ? c_K_MAX : cfg_avg_log2;
  assign w_k         = w_grp_start ? w_cfg_k : r_k;
  assign w_mx        = w_grp_start ? w_cfg_max : r_max;
  assign w_vec_max   = (16'd1 << w_k) - 16'd1;
  assign w_first     = (r_vec == '0);
  assign w_last_vec  = (r_vec == w_vec_max);
  assign w_take      = i_tvalid && w_en && !clear;
  assign w_len_err   = i_tlast != (r_bin == c_LAST_BIN);
  assign w_kill      = w_take && w_len_err;

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      r_bin   <= '0;
      r_vec   <= '0;
      r_k     <= '0;
      r_max   <= 1'b0;
      r_grp   <= 1'b0;
      err_len <= 1'b0;
    end else if (clear) begin
      r_bin <= '0;
      r_vec <= '0;
    end else if (w_take) begin
      if (w_grp_start) begin
        r_k   <= w_cfg_k;
        r_max <= w_mx;
      end
      if (w_len_err) begin
        r_bin   <= '0;
        r_vec   <= '0;
        r_grp   <= ~r_grp;
        err_len <= 1'b1;
      end else if (i_tlast) begin
        r_bin <= '0;
        if (w_last_vec) begin
          r_vec <= '0;
          r_grp <= ~r_grp;
        end else begin
          r_vec <= r_vec + 16'd1;
        end
      end else begin
        r_bin <= r_bin + BIN_W'(1);
      end
    end
  end

  // Pipeline payload; validity is tracked separately so no reset is needed here
  cplx_t            r_s1_smp;
  logic [BIN_W-1:0] r_s1_bin, r_s2_bin;
  logic [3:0]       r_s1_k, r_s2_k;
  logic             r_s1_first, r_s1_emit, r_s1_max, r_s1_grp;
  logic             r_s2_first, r_s2_emit, r_s2_max, r_s2_grp;
  logic             r_s1_vld, r_s2_vld;

  always_ff @(posedge ce_clk) begin
    if (w_en) begin
      r_s1_smp   <= i_tdata;
      r_s1_bin   <= r_bin;
      r_s1_k     <= w_k;
      r_s1_first <= w_first;
      r_s1_emit  <= w_last_vec;
      r_s1_max   <= w_mx;
      r_s1_grp   <= r_grp;
      r_s2_bin   <= r_s1_bin;
      r_s2_k     <= r_s1_k;
      r_s2_first <= r_s1_first;
      r_s2_emit  <= r_s1_emit;
      r_s2_max   <= r_s1_max;
      r_s2_grp   <= r_s1_grp;
    end
  end

  logic [PWR_W-1:0] w_p;

  bin_power_sq u_pwr (
    .clk   (ce_clk),
    .rst   (ce_rst),
    .i_en  (w_en),
    .i_smp (r_s1_smp),
    .o_pwr (w_p)
  );

  logic [ACC_W-1:0] r_ram [VLEN];
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_p_ext, w_sum, w_maxv, w_wdata;
  logic [PWR_W-1:0] w_out;

  assign w_p_ext = {{(ACC_W - PWR_W){1'b0}}, w_p};
  assign w_sum   = r_s2_first ? w_p_ext : r_acc + w_p_ext;
  assign w_maxv  = (r_s2_first || (w_p_ext > r_acc)) ? w_p_ext : r_acc;
  assign w_wdata = r_s2_max ? w_maxv : w_sum;
  assign w_out   = r_s2_max ? PWR_W'(w_maxv) : PWR_W'(w_sum >> r_s2_k);
  assign w_we    = w_en && r_s2_vld && !clear;

  always_ff @(posedge ce_clk) begin
    if (w_we) begin
      r_ram[r_s2_bin] <= w_wdata;
    end
    if (w_en) begin
      r_acc <= r_ram[r_s1_bin];
    end
  end

  // A length error drops in-flight beats of its own group but not the previous one
  assign w_s3_load = r_s2_vld && r_s2_emit && !(w_kill && (r_s2_grp == r_grp));

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
      vec_cnt  <= '0;
    end else begin
      if (o_tvalid && o_tready && o_tlast) begin
        vec_cnt <= vec_cnt + 16'd1;
      end
      if (clear) begin
        r_s1_vld <= 1'b0;
        r_s2_vld <= 1'b0;
        o_tvalid <= 1'b0;
        o_tlast  <= 1'b0;
      end else if (w_en) begin
        r_s1_vld <= w_take && !w_len_err;
        r_s2_vld <= r_s1_vld && !(w_kill && (r_s1_grp == r_grp));
        o_tvalid <= w_s3_load;
        o_tlast  <= w_s3_load && (r_s2_bin == c_LAST_BIN);
        if (w_s3_load) begin
          o_tdata <= w_out;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_energy_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_energy_accum
// Description : Self-checking bench for bin_energy_accum against a group-level
//               averaging model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_energy_accum;

  localparam int VLEN = 8;
  localparam int MAXK = 12;

  logic        ce_clk = 1'b0;
  logic        ce_rst, clear;
  logic [3:0]  cfg_avg_log2;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;
  logic        err_len;
  logic [15:0] vec_cnt;
`ifdef BIN_ENERGY_ACCUM_MAXHOLD_EN
  logic        cfg_max_hold = 1'b0;
`endif

  bin_energy_accum #(.VLEN(VLEN), .MAX_AVG_LOG2(MAXK)) dut (
    .ce_clk       (ce_clk),
    .ce_rst       (ce_rst),
    .cfg_avg_log2 (cfg_avg_log2),
`ifdef BIN_ENERGY_ACCUM_MAXHOLD_EN
    .cfg_max_hold (cfg_max_hold),
`endif
    .clear        (clear),
    .i_tdata      (i_tdata),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .err_len      (err_len),
    .vec_cnt      (vec_cnt)
  );

  always #5 ce_clk = ~ce_clk;

  int cyc = 0;
  always @(posedge ce_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: expected output beats of completed groups, in order
  logic [31:0] exp_q[$];
  bit          exp_last_q[$];
  int          exp_vecs = 0;
  bit          rand_rdy = 1'b0;
  bit          gaps     = 1'b0;
  int          first_acc = -1;
  int          first_out = -1;

  function automatic longint pwr(input logic [31:0] d);
    longint vi, vq;
    vi = longint'($signed(d[31:16]));
    vq = longint'($signed(d[15:0]));
    return vi * vi + vq * vq;
  endfunction

  function automatic logic [31:0] gen(input int mode, input int v);
    case (mode)
      1:       return {16'd3, 16'd4};
      2:       return {16'(v + 1), 16'd0};
      3:       return 32'h8000_8000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge ce_clk);
      #1;
      o_tready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, ready relation
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    forever begin
      @(negedge ce_clk);
      if (ce_rst) begin
        prev_stall = 1'b0;
      end else begin
        check("i_tready_en", i_tready, !o_tvalid || o_tready);
        if (prev_stall) begin
          check("hold_vld", o_tvalid, 1);
          check("hold_data", o_tdata, prev_data);
          check("hold_last", o_tlast, prev_last);
        end
        if (o_tvalid && first_out < 0) first_out = cyc;
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            check("o_tdata", o_tdata, exp_q.pop_front());
            check("o_tlast", o_tlast, exp_last_q.pop_front());
          end
        end
        prev_stall = o_tvalid && !o_tready && !clear;
        prev_data  = o_tdata;
        prev_last  = o_tlast;
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    bit hs;
    int tries = 0;
    if (gaps && $urandom_range(3, 0) == 0) begin
      i_tvalid = 1'b0;
      @(posedge ce_clk);
      #1;
    end
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    forever begin
      @(negedge ce_clk);
      hs = i_tready;
      if (hs && first_acc < 0) first_acc = cyc;
      @(posedge ce_clk);
      #1;
      if (hs) break;
      if (++tries > 1000) begin
        check("in_timeout", 1, 0);
        break;
      end
    end
    i_tvalid = 1'b0;
  endtask

  task automatic run_group(input int mode, input logic [3:0] cfg);
    int          keff;
    longint      sum [VLEN];
    logic [31:0] q[$];
    logic [31:0] d;
    keff = (int'(cfg) > MAXK) ? MAXK : int'(cfg);
    for (int b = 0; b < VLEN; b++) sum[b] = 0;
    for (int v = 0; v < (1 << keff); v++) begin
      for (int b = 0; b < VLEN; b++) begin
        d = gen(mode, v);
        q.push_back(d);
        sum[b] += pwr(d);
      end
    end
    for (int b = 0; b < VLEN; b++) begin
      exp_q.push_back(32'(sum[b] >> keff));
      exp_last_q.push_back(b == VLEN - 1);
    end
    exp_vecs++;
    cfg_avg_log2 = cfg;
    for (int i = 0; i < q.size(); i++) send(q[i], (i % VLEN) == VLEN - 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge ce_clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_last_q.delete();
    end
    repeat (6) @(posedge ce_clk);
    #1;
    check("vec_cnt", vec_cnt, 16'(exp_vecs));
  endtask

  task automatic do_reset();
    ce_rst   = 1'b1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    repeat (3) @(posedge ce_clk);
    #1;
    ce_rst   = 1'b0;
    exp_vecs = 0;
    check("rst_o_tvalid", o_tvalid, 0);
    check("rst_o_tlast", o_tlast, 0);
    check("rst_o_tdata", o_tdata, 0);
    check("rst_i_tready", i_tready, 1);
    check("rst_err_len", err_len, 0);
    check("rst_vec_cnt", vec_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ce_rst = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
    i_tdata = '0; cfg_avg_log2 = '0;
    do_reset();

    // k=0, constant 3+4j, latency from first accept
    run_group(1, 4'd0);
    drain();
    check("latency", 64'(first_out - first_acc), 3);

    // k=2 ramp: one output vector of 7s
    run_group(2, 4'd2);
    drain();

    // Short vector inside a k=2 group, then a clean k=0 vector
    cfg_avg_log2 = 4'd2;
    for (int b = 0; b < VLEN; b++) send($urandom, b == VLEN - 1);
    for (int b = 0; b < 6; b++) send($urandom, b == 5);
    repeat (6) @(posedge ce_clk);
    #1;
    check("err_short", err_len, 1);
    run_group(0, 4'd0);
    drain();

    // Random backpressure at k=1
    rand_rdy = 1'b1;
    gaps     = 1'b1;
    for (int g = 0; g < 3; g++) run_group(0, 4'd1);
    drain();

    // Randomised groups
    for (int g = 0; g < 6; g++) begin
      rand_rdy = 1'($urandom_range(1, 0));
      run_group(0, 4'($urandom_range(3, 0)));
    end
    drain();
    rand_rdy = 1'b0;
    gaps     = 1'b0;

    // clear in vector 2 of a k=2 group, with a colliding beat that must be dropped
    cfg_avg_log2 = 4'd2;
    for (int i = 0; i < 2 * VLEN + 4; i++) send($urandom, (i % VLEN) == VLEN - 1);
    i_tvalid = 1'b1;
    i_tdata  = $urandom;
    i_tlast  = 1'b0;
    clear    = 1'b1;
    @(posedge ce_clk);
    #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    run_group(0, 4'd2);
    drain();

    // ce_rst in vector 2 of a k=2 group
    cfg_avg_log2 = 4'd2;
    for (int i = 0; i < 2 * VLEN + 3; i++) send($urandom, (i % VLEN) == VLEN - 1);
    do_reset();

    // Long vector: bin VLEN-1 without i_tlast
    cfg_avg_log2 = 4'd1;
    for (int b = 0; b < VLEN; b++) send($urandom, 1'b0);
    repeat (6) @(posedge ce_clk);
    #1;
    check("err_long", err_len, 1);
    run_group(0, 4'd1);
    drain();

    // Full-scale input, cfg 15 clamped to MAXK: 48-bit headroom
    run_group(3, 4'd15);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
